// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank.
// Holds bus widths, FSM encoding and the byte-lane merge.
package opb_regbank_pkg;

  localparam int OPB_DW = 32;
  localparam int OPB_BL = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_t;

  // be[0] is the most significant lane (OPB big-endian numbering).
  function automatic logic [OPB_DW-1:0] be_merge(
    input logic [OPB_DW-1:0] old,
    input logic [OPB_DW-1:0] wdata,
    input logic [0:OPB_BL-1] be
  );
    logic [OPB_DW-1:0] r;
    r = old;
    for (int k = 0; k < OPB_BL; k++) begin
      if (be[k]) begin
        r[OPB_DW-1-8*k -: 8] = wdata[OPB_DW-1-8*k -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_regbank_cell.sv
// One control register: byte-lane write, optional self-clear, write strobe.
// Ports: clk, rst, wr_en, be, wdata in; q, wr_stb out.
module opb_regbank_cell
  import opb_regbank_pkg::*;
#(
  parameter bit PULSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [0:OPB_BL-1] be,
  input  logic [OPB_DW-1:0] wdata,
  output logic [OPB_DW-1:0] q,
  output logic              wr_stb
);

  // A pulse register only ever holds a value for the cycle after a
  // write, so clearing it on every non-write edge is sufficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      wr_stb <= 1'b0;
    end else begin
      wr_stb <= wr_en;
      if (wr_en) begin
        q <= be_merge(q, wdata, be);
      end else if (PULSE) begin
        q <= '0;
      end
    end
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit control registers to fabric.
// Ports: OPB slave bus in/out; user_data_out and user_wr_stb to fabric.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010B2400,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B24FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = '0
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:OPB_BL-1]          OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic                       Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_stb
);

  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       offset;
  logic              hit;
  logic              in_rng;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_q;
  logic              in_rng_q;
  logic              rnw_q;
  logic [0:OPB_BL-1] be_q;
  logic [OPB_DW-1:0] wd_q;
  logic [OPB_DW-1:0] rd_q;
  logic              ack;
  logic              wr_go;
  logic [OPB_DW-1:0] regs [C_NUM_REGS];
  logic              unused_ok;

  assign offset = OPB_ABus - C_BASEADDR;
  assign hit    = OPB_select &&
                  (OPB_ABus >= C_BASEADDR) &&
                  (OPB_ABus <= C_HIGHADDR);
  assign in_rng = offset[31:2] < 30'(C_NUM_REGS);
  assign idx    = offset[IW+1:2];

  assign unused_ok = ^{OPB_seqAddr, offset[1:0]};

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat is captured whole at the hit so the ACK cycle does not
  // depend on the master holding address/data stable.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      idx_q    <= '0;
      in_rng_q <= 1'b0;
      rnw_q    <= 1'b0;
      be_q     <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
    end else if (state_q == ST_IDLE && hit) begin
      idx_q    <= idx;
      in_rng_q <= in_rng;
      rnw_q    <= OPB_RNW;
      be_q     <= OPB_BE;
      wd_q     <= OPB_DBus;
      rd_q     <= in_rng ? regs[idx] : '0;
    end
  end

  // A master dropping select during ACK aborts the beat.
  always_comb begin
    ack        = (state_q == ST_ACK) && OPB_select;
    wr_go      = ack && !rnw_q && in_rng_q;
    Sl_xferAck = ack;
    Sl_DBus    = (ack && rnw_q) ? rd_q : '0;
    Sl_errAck  = 1'b0;
    Sl_retry   = 1'b0;
    Sl_toutSup = 1'b0;
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    opb_regbank_cell #(
      .PULSE (C_PULSE_MASK[i])
    ) u_cell (
      .clk    (OPB_Clk),
      .rst    (OPB_Rst),
      .wr_en  (wr_go && (idx_q == IW'(i))),
      .be     (be_q),
      .wdata  (wd_q),
      .q      (regs[i]),
      .wr_stb (user_wr_stb[i])
    );
    assign user_data_out[32*i +: 32] = regs[i];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for the OPB register bank.
// Directed steps plus randomized beats against a word-array model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h010B2400;
  localparam logic [31:0] HIGH = 32'h010B24FF;
  localparam logic [3:0]  PMSK = 4'b0010;

  logic         clk = 1'b0;
  logic         OPB_Rst;
  logic [0:31]  OPB_ABus;
  logic [0:3]   OPB_BE;
  logic [0:31]  OPB_DBus;
  logic         OPB_RNW;
  logic         OPB_select;
  logic         OPB_seqAddr;
  logic [0:31]  Sl_DBus;
  logic         Sl_errAck;
  logic         Sl_retry;
  logic         Sl_toutSup;
  logic         Sl_xferAck;
  logic [127:0] user_data_out;
  logic [3:0]   user_wr_stb;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl [4];

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS   (4),
    .C_PULSE_MASK (64'h2)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (OPB_Rst),
    .OPB_ABus      (OPB_ABus),
    .OPB_BE        (OPB_BE),
    .OPB_DBus      (OPB_DBus),
    .OPB_RNW       (OPB_RNW),
    .OPB_select    (OPB_select),
    .OPB_seqAddr   (OPB_seqAddr),
    .Sl_DBus       (Sl_DBus),
    .Sl_errAck     (Sl_errAck),
    .Sl_retry      (Sl_retry),
    .Sl_toutSup    (Sl_toutSup),
    .Sl_xferAck    (Sl_xferAck),
    .user_data_out (user_data_out),
    .user_wr_stb   (user_wr_stb)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Numeric bit j of be4 is OPB_BE[3-j], which owns bits [8j+7:8j].
  function automatic logic [31:0] lane_mask(input logic [3:0] be4);
    logic [31:0] m;
    m = 32'h0;
    for (int j = 0; j < 4; j++)
      if (be4[j]) m = m | (32'hFF << (8 * j));
    return m;
  endfunction

  function automatic logic [127:0] packed_mdl();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic xfer(input logic [31:0] addr, input bit rnw,
                      input logic [3:0] be4, input logic [31:0] wd,
                      input bit drop);
    bit          hit;
    bit          ok;
    int          idx;
    logic [31:0] exp_rd;
    logic [31:0] m;
    logic [3:0]  exp_stb;
    hit    = (addr >= BASE) && (addr <= HIGH);
    idx    = hit ? int'((addr - BASE) >> 2) : 99;
    exp_rd = (idx < 4) ? mdl[idx] : 32'h0;
    @(posedge clk); #1;
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_BE     = be4;
    OPB_DBus   = wd;
    OPB_select = 1'b1;
    @(negedge clk);
    chk("ack_pre", 128'(Sl_xferAck), 128'(0));
    chk("dbus_pre", 128'(Sl_DBus), 128'(0));
    @(posedge clk); #1;
    if (drop) OPB_select = 1'b0;
    @(negedge clk);
    ok = hit && !drop;
    chk("ack", 128'(Sl_xferAck), 128'(ok));
    chk("rdata", 128'(Sl_DBus), 128'((ok && rnw) ? exp_rd : 32'h0));
    @(posedge clk); #1;
    OPB_select = 1'b0;
    OPB_RNW    = 1'b1;
    exp_stb    = 4'h0;
    if (ok && !rnw && idx < 4) begin
      m        = lane_mask(be4);
      mdl[idx] = (mdl[idx] & ~m) | (wd & m);
      exp_stb[idx] = 1'b1;
    end
    @(negedge clk);
    chk("ack_post", 128'(Sl_xferAck), 128'(0));
    chk("stb", 128'(user_wr_stb), 128'(exp_stb));
    chk("uout", user_data_out, packed_mdl());
    for (int i = 0; i < 4; i++)
      if (PMSK[i]) mdl[i] = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stb_idle", 128'(user_wr_stb), 128'(0));
    chk("uout_clr", user_data_out, packed_mdl());
  endtask

  initial begin
    int          n_ack;
    int          n_stb;
    int          n_hi;
    int          r;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    OPB_Rst     = 1'b1;
    OPB_ABus    = '0;
    OPB_BE      = '0;
    OPB_DBus    = '0;
    OPB_RNW     = 1'b1;
    OPB_select  = 1'b0;
    OPB_seqAddr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 128'(Sl_xferAck), 128'(0));
    chk("rst_dbus", 128'(Sl_DBus), 128'(0));
    chk("rst_uout", user_data_out, 128'(0));
    chk("rst_stb", 128'(user_wr_stb), 128'(0));
    chk("rst_tied", 128'({Sl_errAck, Sl_retry, Sl_toutSup}), 128'(0));
    @(posedge clk); #1;
    OPB_Rst = 1'b0;

    xfer(BASE + 4, 1'b1, 4'hF, 32'h0, 1'b0);
    xfer(BASE, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0);
    chk("reg0_full", 128'(user_data_out[31:0]), 128'(32'hDEADBEEF));
    xfer(BASE, 1'b1, 4'hF, 32'h0, 1'b0);
    xfer(BASE, 1'b0, 4'b0100, 32'h11223344, 1'b0);
    chk("reg0_lane1", 128'(user_data_out[31:0]), 128'(32'hDE22BEEF));
    xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF, 1'b0);
    chk("reg0_be0", 128'(user_data_out[31:0]), 128'(32'hDE22BEEF));

    xfer(BASE + 4, 1'b0, 4'hF, 32'h1, 1'b0);
    xfer(BASE + 4, 1'b1, 4'hF, 32'h0, 1'b0);

    // Streamed writes to the pulse register with select held.
    @(posedge clk); #1;
    OPB_ABus   = BASE + 4;
    OPB_RNW    = 1'b0;
    OPB_BE     = 4'hF;
    OPB_DBus   = 32'h1;
    OPB_select = 1'b1;
    n_ack = 0;
    n_stb = 0;
    n_hi  = 0;
    repeat (5) begin
      @(negedge clk);
      n_ack += int'(Sl_xferAck);
      n_stb += int'(user_wr_stb[1]);
      n_hi  += int'(user_data_out[63:32] == 32'h1);
    end
    OPB_select = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("strm_acks", 128'(n_ack), 128'(2));
    chk("strm_stbs", 128'(n_stb), 128'(2));
    chk("strm_high", 128'(n_hi), 128'(2));
    chk("strm_end", 128'(user_data_out[63:32]), 128'(0));

    xfer(BASE + 32'h10, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0);
    xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b0);
    xfer(32'h010B2500, 1'b1, 4'hF, 32'h0, 1'b0);
    xfer(32'h010B2500, 1'b0, 4'hF, 32'h55AA55AA, 1'b0);
    xfer(BASE + 8, 1'b0, 4'hF, 32'h87654321, 1'b1);
    xfer(BASE + 8, 1'b1, 4'hF, 32'h0, 1'b0);
    xfer(BASE + 12, 1'b0, 4'hF, 32'hA5A5A5A5, 1'b0);

    // Reset arriving in the middle of an ACK cycle.
    @(posedge clk); #1;
    OPB_ABus   = BASE + 8;
    OPB_RNW    = 1'b0;
    OPB_BE     = 4'hF;
    OPB_DBus   = 32'h12345678;
    OPB_select = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", 128'(Sl_xferAck), 128'(1));
    OPB_Rst = 1'b1;
    #1;
    chk("arst_ack", 128'(Sl_xferAck), 128'(0));
    chk("arst_dbus", 128'(Sl_DBus), 128'(0));
    chk("arst_uout", user_data_out, 128'(0));
    chk("arst_stb", 128'(user_wr_stb), 128'(0));
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    OPB_select = 1'b0;
    @(posedge clk); #1;
    OPB_Rst = 1'b0;
    @(negedge clk);
    chk("arst_hold", user_data_out, 128'(0));
    xfer(BASE + 8, 1'b0, 4'hF, 32'h0BADF00D, 1'b0);
    xfer(BASE + 8, 1'b1, 4'hF, 32'h0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      a = BASE + 32'(4 * r);
      else if (r == 6) a = BASE + 32'hFC;
      else if (r == 7) a = HIGH + 1;
      else if (r == 8) a = BASE - 4;
      else             a = BASE + 32'(4 * $urandom_range(0, 3));
      xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
